instr_fetch_buffer: RTL

Fetch front end that drives the program counter's next-address input and consumes its registered output. Each cycle it chooses the next PC (hold, sequential +4, or redirect), issues one instruction-memory request at the current PC, and queues returned instructions, tagged with their PC, in a small FIFO for the decode stage. At most one memory request is outstanding at a time. Redirects flush queued and in-flight instructions.

---
 rtl/instr_fetch_buffer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// Fetch front end: next-PC select, single outstanding imem request, PC-tagged FIFO.
// Optional perf counters FetchCount/StallCycles when FETCH_PERF_EN is defined.
module instr_fetch_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCResult,
   output logic [31:0] Address,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic        IMemRspValid,
   input  logic [31:0] IMemRspData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   input  logic        InstrReady
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCycles
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RSP,
      DROP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pend_pc_q, pend_pc_d;

   logic [31:0] instr_mem_q [DEPTH];
   logic [31:0] pc_mem_q    [DEPTH];

   logic        issue;
   logic        fire;
   logic        push;
   logic        pop;
   logic        full;
   logic [31:0] redir_pc;

   assign full     = (count_q == DEPTH_C);
   assign redir_pc = RedirectTarget & 32'hFFFF_FFFC;

   always_comb begin
      issue = (state_q == IDLE) && !Reset && !Redirect
              && (count_q < DEPTH_C);
      fire  = issue && IMemAck;
      pop   = (count_q != '0) && InstrReady;
      push  = (state_q == WAIT_RSP) && IMemRspValid && !Redirect;

      IMemReq    = issue;
      IMemAddr   = PCResult;
      InstrValid = (count_q != '0);
      Instr      = instr_mem_q[rd_ptr_q];
      InstrPC    = pc_mem_q[rd_ptr_q];

      if (Reset)
         Address = 32'h0;
      else if (Redirect)
         Address = redir_pc;
      else if (fire)
         Address = PCResult + 32'd4;
      else
         Address = PCResult;
   end

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;

      unique case (state_q)
         IDLE: begin
            if (fire) begin
               state_d   = WAIT_RSP;
               pend_pc_d = PCResult;
            end
         end
         WAIT_RSP: begin
            if (IMemRspValid)
               state_d = IDLE;
            else if (Redirect)
               state_d = DROP;
         end
         DROP: begin
            if (IMemRspValid)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A redirect flushes everything, including a same-cycle pop or push
      if (Redirect) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && push) begin
         instr_mem_q[wr_ptr_q] <= IMemRspData;
         pc_mem_q[wr_ptr_q]    <= pend_pc_q;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (pop)
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((state_q == IDLE) && full)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCount  = fetch_cnt_q;
   assign StallCycles = stall_cnt_q;
`endif

endmodule
